// File: rtl/host_pixel_writer.sv
// host_pixel_writer: async host pixel bus to BRAM write port.
// Synchronises host writes, range-checks, queues them, and runs a screen-clear engine.
module host_pixel_writer #(
   parameter int ADDR_W      = 15,
   parameter int PIX_LIMIT   = 30000,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2,
   localparam int PTR_W      = $clog2(FIFO_DEPTH),
   localparam int LVL_W      = PTR_W + 1
) (
   input  logic              clk_10mhz,
   input  logic              reset,
   input  logic              interrupt,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [2:0]        rgb_in,
   input  logic              hold,
   input  logic              clear_req,
   input  logic [2:0]        fill_rgb,
   input  logic              clear_flags,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       wr_data,
   output logic              clear_busy,
   output logic [LVL_W-1:0]  fifo_level,
   output logic              overflow,
   output logic              range_err,
   output logic [7:0]        drop_count
);
   localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(PIX_LIMIT);
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(PIX_LIMIT - 1);
   localparam logic [LVL_W-1:0]  FULL  = LVL_W'(FIFO_DEPTH);

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   logic [SYNC_STAGES-1:0] r_int_sync;
   logic [ADDR_W-1:0]      r_addr_sync [SYNC_STAGES];
   logic [2:0]             r_rgb_sync  [SYNC_STAGES];
   logic                   r_int_prev;
   logic                   r_evt;
   logic [ADDR_W-1:0]      r_evt_addr;
   logic [2:0]             r_evt_rgb;
   logic [ADDR_W+2:0]      r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       r_wptr;
   logic [PTR_W-1:0]       r_rptr;
   state_t                 r_state;
   state_t                 w_next;
   logic [ADDR_W-1:0]      r_cnt;
   logic [2:0]             r_fill;
   logic                   r_bv;
   logic [ADDR_W-1:0]      r_ba;
   logic [2:0]             r_bc;

   logic              w_evt;
   logic              w_full;
   logic              w_empty;
   logic              w_pop;
   logic              w_push;
   logic              w_range_drop;
   logic              w_ovf_drop;
   logic              w_drop;
   logic              w_clr_start;
   logic              w_clr_beat;
   logic [ADDR_W+2:0] w_head;
   logic [15:0]       w_bdata;

   assign w_evt        = r_int_sync[SYNC_STAGES-1] & ~r_int_prev;
   assign w_full       = (fifo_level == FULL);
   assign w_empty      = (fifo_level == '0);
   assign w_range_drop = r_evt & (r_evt_addr >= LIMIT);
   assign w_ovf_drop   = r_evt & ~w_range_drop & w_full & ~w_pop;
   assign w_push       = r_evt & ~w_range_drop & ~w_ovf_drop;
   assign w_drop       = w_range_drop | w_ovf_drop;
   assign w_head       = r_mem[r_rptr];
   assign w_bdata      = {6'b0, r_bc[2], 3'b0, r_bc[1], 3'b0, r_bc[0], 1'b0};
   assign clear_busy   = (r_state == S_CLEAR);

   // Synchronise host strobe, address and colour; remember last strobe stage
   always_ff @(posedge clk_10mhz or posedge reset) begin
      if (reset) begin
         r_int_sync <= '0;
         r_int_prev <= 1'b0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            r_addr_sync[i] <= '0;
            r_rgb_sync[i]  <= '0;
         end
      end else begin
         r_int_sync     <= {r_int_sync[SYNC_STAGES-2:0], interrupt};
         r_int_prev     <= r_int_sync[SYNC_STAGES-1];
         r_addr_sync[0] <= addr_in;
         r_rgb_sync[0]  <= rgb_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_addr_sync[i] <= r_addr_sync[i-1];
            r_rgb_sync[i]  <= r_rgb_sync[i-1];
         end
      end
   end

   // Capture a detected host write event with its address and colour
   always_ff @(posedge clk_10mhz or posedge reset) begin
      if (reset) begin
         r_evt      <= 1'b0;
         r_evt_addr <= '0;
         r_evt_rgb  <= '0;
      end else begin
         r_evt <= w_evt;
         if (w_evt) begin
            r_evt_addr <= r_addr_sync[SYNC_STAGES-1];
            r_evt_rgb  <= r_rgb_sync[SYNC_STAGES-1];
         end
      end
   end

   // Write queue storage, pointers and occupancy
   always_ff @(posedge clk_10mhz or posedge reset) begin
      if (reset) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         fifo_level <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= {r_evt_addr, r_evt_rgb};
            r_wptr        <= r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            fifo_level <= fifo_level + LVL_W'(1);
         end else if (!w_push && w_pop) begin
            fifo_level <= fifo_level - LVL_W'(1);
         end
      end
   end

   // Sticky error flags and saturating drop counter; a drop beats clear_flags
   always_ff @(posedge clk_10mhz or posedge reset) begin
      if (reset) begin
         overflow   <= 1'b0;
         range_err  <= 1'b0;
         drop_count <= '0;
      end else begin
         if (w_range_drop) begin
            range_err <= 1'b1;
         end else if (clear_flags) begin
            range_err <= 1'b0;
         end
         if (w_ovf_drop) begin
            overflow <= 1'b1;
         end else if (clear_flags) begin
            overflow <= 1'b0;
         end
         if (w_drop) begin
            if (clear_flags) begin
               drop_count <= 8'd1;
            end else if (drop_count != 8'hFF) begin
               drop_count <= drop_count + 8'd1;
            end
         end else if (clear_flags) begin
            drop_count <= '0;
         end
      end
   end

   // State register
   always_ff @(posedge clk_10mhz or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state, queue pop and clear beat issue
   always_comb begin
      w_next      = r_state;
      w_pop       = 1'b0;
      w_clr_start = 1'b0;
      w_clr_beat  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (clear_req) begin
               w_next      = S_CLEAR;
               w_clr_start = 1'b1;
            end else if (!hold && !w_empty) begin
               w_pop = 1'b1;
            end
         end
         S_CLEAR: begin
            if (!hold) begin
               w_clr_beat = 1'b1;
               if (r_cnt == LAST) begin
                  w_next = S_IDLE;
               end
            end
         end
      endcase
   end

   // Clear address counter and latched fill colour
   always_ff @(posedge clk_10mhz or posedge reset) begin
      if (reset) begin
         r_cnt  <= '0;
         r_fill <= '0;
      end else if (w_clr_start) begin
         r_cnt  <= '0;
         r_fill <= fill_rgb;
      end else if (w_clr_beat) begin
         r_cnt <= r_cnt + ADDR_W'(1);
      end
   end

   // Beat staging register fed by queue pops or clear beats
   always_ff @(posedge clk_10mhz or posedge reset) begin
      if (reset) begin
         r_bv <= 1'b0;
         r_ba <= '0;
         r_bc <= '0;
      end else begin
         r_bv <= w_pop | w_clr_beat;
         if (w_pop) begin
            r_ba <= w_head[ADDR_W+2:3];
            r_bc <= w_head[2:0];
         end else if (w_clr_beat) begin
            r_ba <= r_cnt;
            r_bc <= r_fill;
         end
      end
   end

   // Registered BRAM write port; address/data hold when idle
   always_ff @(posedge clk_10mhz or posedge reset) begin
      if (reset) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         wr_en <= r_bv;
         if (r_bv) begin
            wr_addr <= r_ba;
            wr_data <= w_bdata;
         end
      end
   end

endmodule

// File: tb/tb_host_pixel_writer.sv
// tb_host_pixel_writer: directed bench for host_pixel_writer.
// Host writes, range/overflow drops, flags, screen clear and reset mid-clear.
`timescale 1ns/1ps
module tb_host_pixel_writer;
   logic        clk_10mhz = 1'b0;
   logic        reset     = 1'b1;
   logic        interrupt = 1'b0;
   logic [14:0] addr_in   = '0;
   logic [2:0]  rgb_in    = '0;
   logic        hold      = 1'b0;
   logic        clear_req = 1'b0;
   logic [2:0]  fill_rgb  = '0;
   logic        clear_flags = 1'b0;
   logic        wr_en;
   logic [14:0] wr_addr;
   logic [15:0] wr_data;
   logic        clear_busy;
   logic [2:0]  fifo_level;
   logic        overflow;
   logic        range_err;
   logic [7:0]  drop_count;

   host_pixel_writer dut (
      .clk_10mhz  (clk_10mhz),
      .reset      (reset),
      .interrupt  (interrupt),
      .addr_in    (addr_in),
      .rgb_in     (rgb_in),
      .hold       (hold),
      .clear_req  (clear_req),
      .fill_rgb   (fill_rgb),
      .clear_flags(clear_flags),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .clear_busy (clear_busy),
      .fifo_level (fifo_level),
      .overflow   (overflow),
      .range_err  (range_err),
      .drop_count (drop_count)
   );

   always #50 clk_10mhz = ~clk_10mhz;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   int t_rise   = 0;
   logic [30:0] beats[$];
   int          beat_cyc[$];

   always @(posedge clk_10mhz) cyc++;

   always @(negedge clk_10mhz) begin
      if (!reset && wr_en) begin
         beats.push_back({wr_addr, wr_data});
         beat_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk_10mhz);
   endtask

   task automatic wr(input logic [14:0] a, input logic [2:0] c,
                     input logic cf);
      @(negedge clk_10mhz);
      addr_in = a;
      rgb_in  = c;
      @(negedge clk_10mhz);
      interrupt = 1'b1;
      t_rise    = cyc + 1;
      @(negedge clk_10mhz);
      @(negedge clk_10mhz);
      interrupt = 1'b0;
      @(negedge clk_10mhz);
      clear_flags = cf;
      @(negedge clk_10mhz);
      clear_flags = 1'b0;
   endtask

   task automatic pulse_flags();
      @(negedge clk_10mhz);
      clear_flags = 1'b1;
      @(negedge clk_10mhz);
      clear_flags = 1'b0;
   endtask

   logic [2:0]  ov_rgb [6] = '{3'd1, 3'd2, 3'd4, 3'd7, 3'd3, 3'd5};
   logic [15:0] ov_dat [4] = '{16'h0002, 16'h0020, 16'h0200, 16'h0222};

   initial begin
      int k;
      int bad;
      int n;

      cycles(3);
      reset = 1'b0;
      cycles(2);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_busy", clear_busy, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_flags", {overflow, range_err, drop_count}, 0);

      // single write
      wr(15'd1234, 3'b101, 1'b0);
      cycles(6);
      chk("single_count", beats.size(), 1);
      chk("single_beat", beats[0], {15'd1234, 16'h0202});
      chk("single_latency", beat_cyc[0], t_rise + 5);
      chk("single_level", fifo_level, 0);
      beats.delete();
      beat_cyc.delete();

      // range reject then last valid pixel
      wr(15'd30000, 3'b111, 1'b0);
      wr(15'd29999, 3'b111, 1'b0);
      cycles(6);
      chk("range_count", beats.size(), 1);
      chk("range_beat", beats[0], {15'd29999, 16'h0222});
      chk("range_err", range_err, 1);
      chk("range_drops", drop_count, 1);
      chk("range_no_ovf", overflow, 0);
      pulse_flags();
      chk("range_cleared", {overflow, range_err, drop_count}, 0);
      beats.delete();
      beat_cyc.delete();

      // overflow under hold
      hold = 1'b1;
      for (int i = 0; i < 6; i++) wr(15'(10 + i), ov_rgb[i], 1'b0);
      cycles(2);
      chk("ovf_level", fifo_level, 4);
      chk("ovf_flag", overflow, 1);
      chk("ovf_drops", drop_count, 2);
      chk("ovf_held", beats.size(), 0);
      hold = 1'b0;
      cycles(8);
      chk("ovf_count", beats.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < beats.size())
            chk("ovf_beat", beats[i], {15'(10 + i), ov_dat[i]});
      end
      if (beats.size() == 4)
         chk("ovf_consec", beat_cyc[3] - beat_cyc[0], 3);
      chk("ovf_drained", fifo_level, 0);
      beats.delete();
      beat_cyc.delete();

      // flags: clear_flags same cycle as an overflow drop
      pulse_flags();
      chk("flags_zero", {overflow, range_err, drop_count}, 0);
      hold = 1'b1;
      for (int i = 0; i < 5; i++) wr(15'(100 + i), 3'd1, 1'b0);
      chk("flags_pre_drop", drop_count, 1);
      wr(15'd105, 3'd1, 1'b1);
      cycles(1);
      chk("flags_drop_wins_ovf", overflow, 1);
      chk("flags_drop_wins_cnt", drop_count, 1);
      pulse_flags();
      chk("flags_alone", {overflow, range_err, drop_count}, 0);
      hold = 1'b0;
      cycles(10);
      beats.delete();
      beat_cyc.delete();

      // full screen clear with a host write in the middle
      @(negedge clk_10mhz);
      clear_req = 1'b1;
      fill_rgb  = 3'b010;
      @(negedge clk_10mhz);
      clear_req = 1'b0;
      fill_rgb  = 3'b000;
      chk("clear_busy_rise", clear_busy, 1);
      cycles(50);
      wr(15'd777, 3'b001, 1'b0);
      cycles(1);
      chk("clear_mid_level", fifo_level, 1);
      k = 0;
      while (clear_busy && k < 31000) begin
         @(negedge clk_10mhz);
         k++;
      end
      chk("clear_done", clear_busy, 0);
      cycles(8);
      chk("clear_count", beats.size(), 30001);
      bad = 0;
      for (int i = 0; i < 30000 && i < beats.size(); i++) begin
         if (beats[i] !== {15'(i), 16'h0020}) bad++;
      end
      chk("clear_beats", bad, 0);
      if (beats.size() == 30001) begin
         chk("clear_consec", beat_cyc[29999] - beat_cyc[0], 29999);
         chk("clear_host_after", beats[30000], {15'd777, 16'h0002});
      end
      beats.delete();
      beat_cyc.delete();

      // reset in the middle of a clear
      @(negedge clk_10mhz);
      clear_req = 1'b1;
      fill_rgb  = 3'b111;
      @(negedge clk_10mhz);
      clear_req = 1'b0;
      wr(15'd500, 3'b011, 1'b0);
      k = 0;
      while (beats.size() < 101 && k < 500) begin
         @(negedge clk_10mhz);
         k++;
      end
      chk("rmid_reach", beats.size() >= 101, 1);
      chk("rmid_pre_level", fifo_level, 1);
      #2 reset = 1'b1;
      #1;
      chk("rmid_wr_en", wr_en, 0);
      chk("rmid_wr_addr", wr_addr, 0);
      chk("rmid_wr_data", wr_data, 0);
      chk("rmid_busy", clear_busy, 0);
      chk("rmid_level", fifo_level, 0);
      n = beats.size();
      @(negedge clk_10mhz);
      reset = 1'b0;
      cycles(20);
      chk("rmid_no_beats", beats.size(), n);
      chk("rmid_idle", clear_busy, 0);
      chk("rmid_level_after", fifo_level, 0);
      beats.delete();
      beat_cyc.delete();

      // drop counter saturation
      for (int i = 0; i < 300; i++) wr(15'h7FFF, 3'd0, 1'b0);
      cycles(4);
      chk("sat_count", drop_count, 255);
      chk("sat_range", range_err, 1);
      chk("sat_no_beats", beats.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end
endmodule
